// File: rtl/audio_pkg.sv
// Shared types and default constants for the audio sample recorder.
//   rec_state_t          : recorder FSM state encoding
//   AUDIO_SAMPLE_WIDTH   : sample / BRAM word width
//   DEFAULT_*            : default clock, sample rate and BRAM depth
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    DONE = 2'd2
  } rec_state_t;

  localparam int unsigned AUDIO_SAMPLE_WIDTH     = 8;
  localparam int unsigned DEFAULT_CLK_FREQ_HZ    = 100_000_000;
  localparam int unsigned DEFAULT_SAMPLE_RATE_HZ = 8_000;
  localparam int unsigned DEFAULT_RAM_DEPTH      = 40_000;  // 5 s at 8 kHz

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick generator.
//   clk_in   : system clock
//   rst_in   : asynchronous, active-low reset
//   clear_in : synchronous clear of the divider counter (restart the period)
//   en_in    : count enable; the counter freezes while low
//   tick_out : high for one cycle when the counter sits at TICK_DIV-1 and en_in is high
module sample_tick_gen #(
  parameter int unsigned TICK_DIV = 12_500
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic en_in,
  output logic tick_out
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_out = en_in && (cnt_q == LAST);

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else if (clear_in) begin
      cnt_q <= '0;
    end else if (en_in) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/audio_sample_recorder.sv
// Write side of the audio sample BRAM: latches the incoming sample stream into
// a hold register and writes it to BRAM port B once per sample tick.
//   clk_in / rst_in          : system clock, asynchronous active-low reset
//   start_in / stop_in       : 1-cycle control pulses (start wins when both)
//   loop_in                  : sampled on start; 1 = circular, 0 = one-shot
//   sample_in/sample_valid_in: incoming sample stream
//   addrb_out/dinb_out/web_out : registered BRAM port-B write interface
//   recording_out, full_out, length_out : capture status
//   underrun_out, overrun_out: sticky stream-timing flags, cleared on start
module audio_sample_recorder
  import audio_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = DEFAULT_CLK_FREQ_HZ,
  parameter int unsigned SAMPLE_RATE_HZ = DEFAULT_SAMPLE_RATE_HZ,
  parameter int unsigned RAM_DEPTH      = DEFAULT_RAM_DEPTH,
  parameter int unsigned SAMPLE_WIDTH   = AUDIO_SAMPLE_WIDTH,
  localparam int unsigned ADDR_WIDTH    = $clog2(RAM_DEPTH)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic                    loop_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic [ADDR_WIDTH-1:0]   addrb_out,
  output logic [SAMPLE_WIDTH-1:0] dinb_out,
  output logic                    web_out,
  output logic                    recording_out,
  output logic                    full_out,
  output logic [ADDR_WIDTH:0]     length_out,
  output logic                    underrun_out,
  output logic                    overrun_out
);

  localparam int unsigned TICK_DIV  = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  FULL_LEN  = LEN_WIDTH'(RAM_DEPTH);

  rec_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [SAMPLE_WIDTH-1:0] hold_q;
  logic                    fresh_q;
  logic                    loop_q;
  logic                    finish_q;   // last write is on the port; leave REC next edge
  logic                    tick;
  logic                    tick_eff;
  logic                    last_write;

  sample_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (start_in),
    .en_in    (state_q == REC),
    .tick_out (tick)
  );

  // A start in the tick cycle restarts the capture, so that write is dropped.
  assign tick_eff      = tick && !start_in;
  assign last_write    = tick_eff && !loop_q && (addr_q == LAST_ADDR);
  assign recording_out = (state_q == REC);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_in) state_d = REC;
      REC: begin
        if (start_in)                 state_d = REC;
        else if (finish_q)            state_d = DONE;
        else if (stop_in && !tick_eff) state_d = DONE;
      end
      DONE: if (start_in) state_d = REC;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold register and stream-timing flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_q       <= '0;
      fresh_q      <= 1'b0;
      underrun_out <= 1'b0;
      overrun_out  <= 1'b0;
    end else begin
      if (sample_valid_in) hold_q <= sample_in;
      if (start_in) begin
        fresh_q      <= 1'b0;
        underrun_out <= 1'b0;
        overrun_out  <= 1'b0;
      end else begin
        // A valid in the tick cycle belongs to the next interval, not this one.
        if (sample_valid_in && fresh_q && !tick_eff && state_q == REC) overrun_out <= 1'b1;
        if (tick_eff && !fresh_q) underrun_out <= 1'b1;
        if (sample_valid_in)      fresh_q <= 1'b1;
        else if (tick_eff)        fresh_q <= 1'b0;
      end
    end
  end

  // Address/length counters and registered port-B outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_q     <= '0;
      loop_q     <= 1'b0;
      finish_q   <= 1'b0;
      full_out   <= 1'b0;
      length_out <= '0;
      addrb_out  <= '0;
      dinb_out   <= '0;
      web_out    <= 1'b0;
    end else begin
      web_out  <= tick_eff;
      finish_q <= tick_eff && (stop_in || last_write);
      if (start_in) begin
        addr_q     <= '0;
        length_out <= '0;
        loop_q     <= loop_in;
        full_out   <= 1'b0;
      end else begin
        if (tick_eff) begin
          addrb_out <= addr_q;
          dinb_out  <= hold_q;
          addr_q    <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          if (length_out != FULL_LEN) length_out <= length_out + 1'b1;
        end
        if (finish_q && !loop_q && length_out == FULL_LEN) full_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_recorder.sv
module tb_audio_sample_recorder;

  localparam int TICK_DIV  = 4;
  localparam int RAM_DEPTH = 8;
  localparam int AW        = 3;
  localparam int SW        = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in = 1'b0;
  logic          stop_in = 1'b0;
  logic          loop_in = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid_in = 1'b0;
  logic [AW-1:0] addrb_out;
  logic [SW-1:0] dinb_out;
  logic          web_out;
  logic          recording_out;
  logic          full_out;
  logic [AW:0]   length_out;
  logic          underrun_out;
  logic          overrun_out;

  wr_t sb_q[$];
  wr_t exp_wr;
  int  checks = 0;
  int  errors = 0;

  audio_sample_recorder #(
    .CLK_FREQ_HZ    (TICK_DIV * 2),
    .SAMPLE_RATE_HZ (2),
    .RAM_DEPTH      (RAM_DEPTH),
    .SAMPLE_WIDTH   (SW)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .stop_in         (stop_in),
    .loop_in         (loop_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .addrb_out       (addrb_out),
    .dinb_out        (dinb_out),
    .web_out         (web_out),
    .recording_out   (recording_out),
    .full_out        (full_out),
    .length_out      (length_out),
    .underrun_out    (underrun_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk_in) begin
    if (web_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {31'd0, web_out}, 32'd0);
      end else begin
        exp_wr = sb_q.pop_front();
        check("wr_addr", {29'd0, addrb_out}, {29'd0, exp_wr.addr});
        check("wr_data", {24'd0, dinb_out}, {24'd0, exp_wr.data});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_sample(input logic [SW-1:0] v);
    sample_valid_in = 1'b1;
    sample_in       = v;
    step(1);
    sample_valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
  endtask

  // One sample early in the tick period, expected to land at addr.
  task automatic tick_with(input logic [SW-1:0] v, input logic [AW-1:0] addr);
    sb_q.push_back('{addr: addr, data: v});
    pulse_sample(v);
    step(TICK_DIV - 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_web"}, {31'd0, web_out}, 32'd0);
    check({tag, "_addrb"}, {29'd0, addrb_out}, 32'd0);
    check({tag, "_dinb"}, {24'd0, dinb_out}, 32'd0);
    check({tag, "_rec"}, {31'd0, recording_out}, 32'd0);
    check({tag, "_full"}, {31'd0, full_out}, 32'd0);
    check({tag, "_len"}, {28'd0, length_out}, 32'd0);
    check({tag, "_udr"}, {31'd0, underrun_out}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun_out}, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    #2 rst_in = 1'b0;
    step(2);
    check_outputs_zero("reset");
    rst_in = 1'b1;
    step(2);

    // One-shot capture fills the RAM, then stops with no ninth write.
    loop_in = 1'b0;
    pulse_start();
    for (int i = 0; i < RAM_DEPTH; i++) tick_with(SW'(i + 1), AW'(i));
    step(2);
    check("oneshot_full", {31'd0, full_out}, 32'd1);
    check("oneshot_len", {28'd0, length_out}, 32'd8);
    check("oneshot_rec", {31'd0, recording_out}, 32'd0);
    step(3 * TICK_DIV);
    check("oneshot_drained", sb_q.size(), 32'd0);

    // Loop capture wraps the address and keeps recording.
    loop_in = 1'b1;
    pulse_start();
    loop_in = 1'b0;
    for (int i = 0; i < 10; i++) tick_with(SW'(10 + i), AW'(i % RAM_DEPTH));
    check("loop_len", {28'd0, length_out}, 32'd8);
    check("loop_rec", {31'd0, recording_out}, 32'd1);
    check("loop_full", {31'd0, full_out}, 32'd0);
    check("loop_udr_clean", {31'd0, underrun_out}, 32'd0);
    check("loop_ovr_clean", {31'd0, overrun_out}, 32'd0);

    // Underrun: no sample this period, the held 19 is written again.
    sb_q.push_back('{addr: 3'd2, data: 8'd19});
    step(TICK_DIV);
    check("underrun_set", {31'd0, underrun_out}, 32'd1);
    check("underrun_no_ovr", {31'd0, overrun_out}, 32'd0);

    // Overrun: three samples in one period, the last one wins.
    sb_q.push_back('{addr: 3'd3, data: 8'd7});
    pulse_sample(8'd5);
    pulse_sample(8'd6);
    pulse_sample(8'd7);
    check("overrun_set", {31'd0, overrun_out}, 32'd1);
    step(1);

    // Stop coincident with a tick: that write still happens, then DONE.
    sb_q.push_back('{addr: 3'd4, data: 8'd42});
    pulse_sample(8'd42);
    step(TICK_DIV - 2);
    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    step(2);
    check("stop_tick_rec", {31'd0, recording_out}, 32'd0);
    check("stop_tick_full", {31'd0, full_out}, 32'd0);
    check("stop_tick_len", {28'd0, length_out}, 32'd8);
    check("stop_tick_drained", sb_q.size(), 32'd0);

    // Start and stop together: start wins, capture restarts at addr 0.
    start_in = 1'b1;
    stop_in  = 1'b1;
    step(1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    check("start_stop_rec", {31'd0, recording_out}, 32'd1);
    check("start_stop_len", {28'd0, length_out}, 32'd0);
    check("start_stop_ovr", {31'd0, overrun_out}, 32'd0);
    tick_with(8'd55, 3'd0);
    tick_with(8'd56, 3'd1);
    tick_with(8'd57, 3'd2);
    sb_q.push_back('{addr: 3'd3, data: 8'd57});
    step(TICK_DIV);
    check("restart_pre_udr", {31'd0, underrun_out}, 32'd1);

    // Restart while recording: flags and length cleared, next write at addr 0.
    pulse_start();
    check("restart_udr", {31'd0, underrun_out}, 32'd0);
    check("restart_len0", {28'd0, length_out}, 32'd0);
    tick_with(8'd60, 3'd0);
    check("restart_len1", {28'd0, length_out}, 32'd1);

    // Reset in the middle of a write cycle.
    tick_with(8'd61, 3'd1);
    pulse_sample(8'd62);
    step(TICK_DIV - 1);
    check("pre_reset_web", {31'd0, web_out}, 32'd1);
    rst_in = 1'b0;
    #1;
    check_outputs_zero("midrec_reset");
    step(2);
    rst_in = 1'b1;
    step(4 * TICK_DIV);
    check("post_reset_rec", {31'd0, recording_out}, 32'd0);
    check("final_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
